// File: rtl/result_reporter.sv
// result_reporter: core-run control and daisy-chained SPI result readout.
// Releases the hasher pool from reset on a job start, captures the first
// {match_flags, nonce} the pool reports, raises READY, and shifts the captured
// result out on the daisy SPI(1) bus while passing upstream bits through.
//
// Handshake: start is a one-cycle pulse; success_in/result_in are level
// signals sampled every clk, and result_in is only meaningful while
// success_in=1. The SPI pins are asynchronous and are synchronised before use.
module result_reporter #(
    parameter int RESULT_WIDTH = 40,
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_WIDTH    = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    success_in,
    input  logic [RESULT_WIDTH-1:0] result_in,
    input  logic                    sck1_in,
    input  logic                    sdi1_in,
    input  logic                    cs1_n_in,
    output logic                    sdo1_out,
    output logic                    core_reset_n_out,
    output logic                    ready_out
);

    // SYNC_STAGES must be at least 2 and 2^CNT_WIDTH must exceed RESULT_WIDTH.

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(RESULT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] cs_n_sync_q;
    logic                   sck_prev_q;
    logic                   cs_n_prev_q;

    logic sck_s;
    logic sdi_s;
    logic cs_n_s;
    logic sck_rise;
    logic cs_n_fall;
    logic cs_n_rise;

    // Synchroniser chains plus one delayed copy for edge detection; idle levels on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= '0;
            sdi_sync_q  <= '0;
            cs_n_sync_q <= '1;
            sck_prev_q  <= 1'b0;
            cs_n_prev_q <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck1_in};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi1_in};
            cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs1_n_in};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_n_prev_q <= cs_n_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign cs_n_fall = ~cs_n_s & cs_n_prev_q;
    assign cs_n_rise = cs_n_s & ~cs_n_prev_q;

    // ------------------------------------------------------------------
    // Run-control state machine
    // ------------------------------------------------------------------
    state_t                  state_q;
    state_t                  state_d;
    logic                    core_reset_n_q;
    logic                    core_reset_n_d;
    logic                    ready_q;
    logic                    ready_d;
    logic                    capture_en;
    logic [RESULT_WIDTH-1:0] result_q;
    logic [RESULT_WIDTH-1:0] shift_q;
    logic [CNT_WIDTH-1:0]    bit_cnt_q;
    logic                    sdo_q;
    logic                    read_complete;

    // A readout only counts as complete once a full result has been clocked out.
    assign read_complete = cs_n_rise && (bit_cnt_q >= CNT_FULL);

    // State register and registered pool-reset / READY outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_HALT;
            core_reset_n_q <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            core_reset_n_q <= core_reset_n_d;
            ready_q        <= ready_d;
        end
    end

    // Next state and next output values; start beats a same-cycle success.
    always_comb begin
        state_d        = state_q;
        core_reset_n_d = 1'b0;
        ready_d        = 1'b0;
        capture_en     = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (start) begin
                    state_d        = ST_RUN;
                    core_reset_n_d = 1'b1;
                end
            end
            ST_RUN: begin
                core_reset_n_d = 1'b1;
                if (start) begin
                    // New job: pulse the pool reset for one cycle, stay in RUN.
                    core_reset_n_d = 1'b0;
                end else if (success_in) begin
                    capture_en     = 1'b1;
                    state_d        = ST_DONE;
                    core_reset_n_d = 1'b0;
                    ready_d        = 1'b1;
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                if (read_complete) begin
                    state_d = ST_HALT;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Captured result register, written only on the winning success.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else if (capture_en) begin
            result_q <= result_in;
        end
    end

    // ------------------------------------------------------------------
    // Daisy shift path
    // ------------------------------------------------------------------

    // Shift register and bit counter; a chip-select fall wins over a same-cycle sck rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (cs_n_fall) begin
            shift_q   <= (state_q == ST_DONE) ? result_q : '0;
            bit_cnt_q <= '0;
        end else if (sck_rise && !cs_n_s) begin
            shift_q <= {shift_q[RESULT_WIDTH-2:0], sdi_s};
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // Registered serial output: MSB of the shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sdo_q <= 1'b0;
        end else begin
            sdo_q <= shift_q[RESULT_WIDTH-1];
        end
    end

    assign sdo1_out         = sdo_q;
    assign core_reset_n_out = core_reset_n_q;
    assign ready_out        = ready_q;

endmodule

// File: doc/result_reporter.md
Name: result_reporter

Overview:
- Sits directly downstream of the hasher pool (shapool) and alongside the job-config loader inside the external IO path.
- Owns the core-run control:
  - releases the pool from reset when a job is started;
  - captures the first {match_flags, nonce} the pool reports and holds the pool in reset afterwards;
  - raises READY;
  - serialises the captured result onto the daisy-chained SPI(1) bus, passing upstream devices' bits through.

Parameters:
- RESULT_WIDTH, 40, captured result width: {match_flags[7:0], nonce[31:0]}.
- SYNC_STAGES, 2, flop stages on each asynchronous SPI input (sck1, sdi1, cs1_n); minimum 2.
- CNT_WIDTH, 6, width of the shifted-bit counter; must satisfy 2^CNT_WIDTH > RESULT_WIDTH.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse from the job loader: job_config is valid, begin hashing.
- success_in, input, 1, pool success flag; level, sampled every clk.
- result_in, input, RESULT_WIDTH, {match_flags, nonce} from the pool; valid while success_in=1.
- sck1_in, input, 1, daisy SPI clock (asynchronous).
- sdi1_in, input, 1, daisy SPI data from the upstream device (asynchronous).
- cs1_n_in, input, 1, daisy SPI chip select, active low (asynchronous).
- sdo1_out, output, 1, daisy SPI data to the downstream device.
- core_reset_n_out, output, 1, pool reset; 0 holds the pool in reset.
- ready_out, output, 1, result available; drives the open-drain READY pin at top level.

Behaviour:

Reset (reset=1 at a clk edge):
- State = HALT; core_reset_n_out=0, ready_out=0, sdo1_out=0.
- Shift register, captured result and bit counter cleared; synchroniser flops cleared to idle levels (sck=0, cs_n=1).
- Reset mid-operation aborts any shift or run. No partial result survives.

Input synchronisation and edge detection:
- Each SPI input passes through SYNC_STAGES flops. Edges are detected on the last synchronised stage against a one-cycle-delayed copy.
- Required sck1 frequency ≤ clk/8.

State machine (registered outputs):
- HALT
  - core_reset_n_out=0, ready_out=0.
  - start -> RUN.
- RUN
  - core_reset_n_out=1, ready_out=0.
  - success_in=1 -> capture result_in into the result register; go to DONE in the same cycle.
  - start while in RUN (new job) -> core_reset_n_out=0 for exactly one cycle, then back to RUN with core_reset_n_out=1.
  - If start and success_in are both 1 in the same cycle, start wins: result discarded, pool restarted.
- DONE
  - core_reset_n_out=0, ready_out=1.
  - The captured result is held until read out.
  - start is ignored in DONE.
  - Leave to HALT only when cs1_n rises (synchronised) with bit counter ≥ RESULT_WIDTH. ready_out falls in the cycle after that edge is detected.
  - cs1_n rising with counter < RESULT_WIDTH: stay in DONE and keep the captured result; the next transaction reloads it.

Daisy shift path:
- Shift register is RESULT_WIDTH bits wide and operates in every state.
- cs1_n falling edge:
  - load the shift register with the captured result if state=DONE, else all zeros;
  - clear the bit counter.
- sck1 rising edge while cs1_n=0:
  - shift left, with synchronised sdi1 entering the LSB;
  - bit counter increments, saturating at 2^CNT_WIDTH-1.
- sck1 edges while cs1_n=1 are ignored.
- sdo1_out = shift register MSB, registered, updated the cycle after each load or shift.
  - Consequence: the first bit (result bit 39) is valid before the first sck1 rise.
  - The bus master samples on sck1 rising edges.
- A chain of N devices requires N×RESULT_WIDTH clocks. Bits beyond RESULT_WIDTH are upstream data passing through.
- cs1_n falling and sck1 rising detected in the same clk cycle: the load takes priority; the shift is dropped.

Latency:
- success_in to ready_out=1: 1 clk.
- start (from HALT) to core_reset_n_out=1: 1 clk.

Test Plan:
1. Reset, pulse start -> core_reset_n_out=1 after 1 clk, ready_out=0. Assert success_in with result_in=40'hA5_DEADBEEF -> next clk: ready_out=1, core_reset_n_out=0.
2. From scenario 1: cs1_n low, 40 sck1 pulses at clk/8 with sdi1=0, then cs1_n high.
   - sdo1_out sequence is 0xA5DEADBEEF, MSB first.
   - ready_out=0 and state HALT after cs1_n rises.
   - A following start re-enables the core.
3. Daisy pass-through in RUN: cs1_n low, 80 sck1 pulses, sdi1 carrying 0x123456789A then 0x0 -> sdo1_out emits 40 zeros then 0x123456789A. ready_out stays 0 and core_reset_n_out stays 1.
4. Partial readout in DONE: 20 sck1 pulses, then cs1_n high -> ready_out stays 1. A second full 40-bit read returns the complete original value and then clears ready_out.
5. Restart and collision:
   - start while in RUN -> core_reset_n_out low for exactly 1 clk.
   - start and success_in in the same cycle -> ready_out stays 0, core_reset_n_out pulses low for 1 clk.
   - start while in DONE -> no change.
6. Reset mid-shift (after 10 sck1 pulses in DONE) -> next clk: ready_out=0, core_reset_n_out=0, sdo1_out=0. A subsequent cs1_n fall loads zeros.
